// File: rtl/bcd_convert_scheduler.sv
// bcd_convert_scheduler: round-robin arbiter that time-shares one external
// 14-bit binary-to-BCD converter among NUM_CH requesters. Each value is
// clamped to MAX_VAL, the converter is started with a one-cycle pulse, and
// the result is parked in a per-channel BCD holding register. A converter
// that never returns to idle is abandoned after TIMEOUT cycles in WAIT and
// flags a sticky error.

// Per-channel BCD holding register, rewritten only on its own completion.
module bcd_convert_slice (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  output logic [15:0] bcd_q
);
  logic [15:0] bcd_d;

  // Hold unless this channel's conversion just completed.
  always_comb begin
    bcd_d = bcd_q;
    if (wr_en) bcd_d = wr_data;
  end

  // Holding register.
  always_ff @(posedge clk) begin
    if (reset) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  end
endmodule

module bcd_convert_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int MAX_VAL = 9999,
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH*14-1:0] value,
  output logic [NUM_CH-1:0]    ack,
  output logic [NUM_CH-1:0]    done,
  output logic [NUM_CH*16-1:0] bcd,
  output logic                 busy,
  output logic                 err,
  output logic                 conv_start,
  output logic [13:0]          conv_in,
  input  logic [1:0]           conv_state,
  input  logic [15:0]          conv_bcd
);
  localparam int          CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int          CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [13:0] MAX14 = 14'(MAX_VAL);

  typedef enum logic [1:0] {S_ARB = 2'd0, S_START = 2'd1, S_WAIT = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    last_q, last_d;
  logic [CH_W-1:0]    cur_q, cur_d;
  logic [13:0]        conv_in_q, conv_in_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [NUM_CH-1:0]  done_q, done_d;

  logic               gnt_vld;
  logic [CH_W-1:0]    gnt_idx;
  logic [13:0]        gnt_val;
  logic [13:0]        gnt_clamp;
  logic               wr_en;
  int                 idx;

  // Round-robin scan starting just after the last granted channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

  // Select the granted operand and clamp it (unsigned 14-bit compare).
  always_comb begin
    gnt_val   = value[int'(gnt_idx)*14 +: 14];
    gnt_clamp = (gnt_val > MAX14) ? MAX14 : gnt_val;
  end

  // Scheduler FSM: next state, grant/start pulses, completion and timeout.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cur_d      = cur_q;
    conv_in_d  = conv_in_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    done_d     = '0;
    ack        = '0;
    conv_start = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      S_ARB: begin
        if (gnt_vld && !reset) begin
          ack[gnt_idx] = 1'b1;
          conv_in_d    = gnt_clamp;
          cur_d        = gnt_idx;
          last_d       = gnt_idx;
          state_d      = S_START;
        end
      end
      S_START: begin
        conv_start = !reset;
        cnt_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // Saturate so a stuck converter cannot wrap the counter.
        if (cnt_q != CNT_W'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
        if (conv_state == 2'b00) begin
          wr_en         = 1'b1;
          done_d[cur_q] = 1'b1;
          state_d       = S_ARB;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          // Acked request is dropped; its slice keeps the old result.
          err_d   = 1'b1;
          state_d = S_ARB;
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_ARB;
      last_q    <= CH_W'(NUM_CH - 1);
      cur_q     <= '0;
      conv_in_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cur_q     <= cur_d;
      conv_in_q <= conv_in_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_slice
      bcd_convert_slice u_slice (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en && (cur_q == CH_W'(i))),
        .wr_data (conv_bcd),
        .bcd_q   (bcd[16*i +: 16])
      );
    end
  endgenerate

  assign done    = done_q;
  assign err     = err_q;
  assign conv_in = conv_in_q;
  assign busy    = (state_q != S_ARB);
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Bench for bcd_convert_scheduler: drives a behavioural converter and checks
// grants, timing and BCD slices against a round-robin / decimal-digit model.
module tb_bcd_convert_scheduler;
  localparam int NUM_CH  = 4;
  localparam int MAX_VAL = 9999;
  localparam int TIMEOUT = 40;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_CH-1:0]    req = '0;
  logic [NUM_CH*14-1:0] value = '0;
  logic [NUM_CH-1:0]    ack, done;
  logic [NUM_CH*16-1:0] bcd;
  logic                 busy, err, conv_start;
  logic [13:0]          conv_in;
  logic [1:0]           conv_state;
  logic [15:0]          conv_bcd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] m_bcd [NUM_CH];
  int          m_last;
  bit          m_err;

  bit          stuck = 1'b0;
  int          ccnt = 0;
  logic [15:0] cres = '0;

  bcd_convert_scheduler #(.NUM_CH(NUM_CH), .MAX_VAL(MAX_VAL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .value(value), .ack(ack), .done(done),
    .bcd(bcd), .busy(busy), .err(err), .conv_start(conv_start), .conv_in(conv_in),
    .conv_state(conv_state), .conv_bcd(conv_bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int clampv(input int v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  function automatic int rr_pick(input logic [NUM_CH-1:0] mask, input int last);
    for (int k = 1; k <= NUM_CH; k++)
      if (mask[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
    return -1;
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input int c);
    return NUM_CH'(1) << c;
  endfunction

  function automatic logic [NUM_CH*16-1:0] mvec();
    logic [NUM_CH*16-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[16*i +: 16] = m_bcd[i];
    return v;
  endfunction

  // Nominal converter: busy for G+2..G+30, idle again (result valid) at G+31.
  always @(posedge clk) begin
    if (reset) begin
      ccnt <= 0;
      cres <= '0;
    end else if (conv_start) begin
      ccnt <= 29;
      cres <= to_bcd(int'(conv_in));
    end else if (ccnt != 0) begin
      ccnt <= ccnt - 1;
    end
  end
  assign conv_state = (stuck || ccnt != 0) ? 2'b01 : 2'b00;
  assign conv_bcd   = cres;

  task automatic model_reset;
    for (int i = 0; i < NUM_CH; i++) m_bcd[i] = '0;
    m_last = NUM_CH - 1;
    m_err  = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  task automatic wait_ack(input int bound, output int g, output bit ok);
    ok = 1'b0;
    g  = cyc;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (ack !== '0) begin ok = 1'b1; g = cyc; end
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if ({ack, done, busy, err, conv_start} !== '0) begin errors++;
      $display("FAIL reset_ctrl: got ack=%b done=%b busy=%b err=%b start=%b expected all 0", ack, done, busy, err, conv_start); end
    checks++; if (bcd !== '0) begin errors++; $display("FAIL reset_bcd: got %h expected 0", bcd); end
    checks++; if (conv_in !== '0) begin errors++; $display("FAIL reset_conv_in: got %0d expected 0", conv_in); end
  endtask

  task automatic test_single;
    int g, exp; bit ok;
    @(posedge clk); #1;
    value[0 +: 14] = 14'd1234; req[0] = 1'b1;
    exp = rr_pick(4'b0001, m_last);
    wait_ack(10, g, ok);
    checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL single_ack: got %b expected %b", ack, onehot(exp)); end
    m_last = exp;
    @(posedge clk); #1 req[0] = 1'b0;
    at_cycle(g + 1);
    checks++; if (conv_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_start: got start=%b busy=%b expected 1 1", conv_start, busy); end
    checks++; if (conv_in !== 14'd1234) begin errors++; $display("FAIL single_conv_in: got %0d expected 1234", conv_in); end
    at_cycle(g + 31);
    checks++; if (done !== '0 || bcd !== mvec()) begin errors++; $display("FAIL single_early: got done=%b bcd=%h expected 0 %h", done, bcd, mvec()); end
    at_cycle(g + 32);
    m_bcd[0] = to_bcd(1234);
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b expected 0001", done); end
    checks++; if (bcd !== mvec()) begin errors++; $display("FAIL single_bcd: got %h expected %h", bcd, mvec()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_clamp;
    int g, exp; bit ok;
    int vals [2];
    vals[0] = 16383; vals[1] = 0;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      value[28 +: 14] = 14'(vals[n]); req[2] = 1'b1;
      exp = rr_pick(4'b0100, m_last);
      wait_ack(10, g, ok);
      checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL clamp_ack%0d: got %b expected %b", n, ack, onehot(exp)); end
      m_last = exp;
      @(posedge clk); #1 req[2] = 1'b0;
      at_cycle(g + 32);
      m_bcd[2] = to_bcd(clampv(vals[n]));
      checks++; if (done !== onehot(2) || bcd[47:32] !== m_bcd[2]) begin errors++;
        $display("FAIL clamp_bcd%0d: got done=%b slice=%h expected %b %h", n, done, bcd[47:32], onehot(2), m_bcd[2]); end
      checks++; if (bcd !== mvec()) begin errors++; $display("FAIL clamp_hold%0d: got %h expected %h", n, bcd, mvec()); end
    end
  endtask

  task automatic test_all_four;
    int g, exp; bit ok;
    int vals [NUM_CH];
    logic [NUM_CH-1:0] pend;
    vals[0] = 1; vals[1] = 22; vals[2] = 333; vals[3] = 4444;
    @(posedge clk); #1;
    for (int i = 0; i < NUM_CH; i++) value[14*i +: 14] = 14'(vals[i]);
    req = '1; pend = '1;
    do_reset();
    wait_ack(5, g, ok);
    for (int n = 0; n < NUM_CH; n++) begin
      exp = rr_pick(pend, m_last);
      checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL all4_ack%0d: got %b expected %b", n, ack, onehot(exp)); end
      ok = 1'b1; m_last = exp; pend[exp] = 1'b0;
      @(posedge clk); #1 req[exp] = 1'b0;
      at_cycle(g + 32); g += 32;
      m_bcd[exp] = to_bcd(clampv(vals[exp]));
      checks++; if (done !== onehot(exp) || bcd !== mvec()) begin errors++;
        $display("FAIL all4_done%0d: got done=%b bcd=%h expected %b %h", n, done, bcd, onehot(exp), mvec()); end
    end
  endtask

  task automatic test_fairness;
    int g, exp; bit ok;
    int vals [NUM_CH];
    logic [NUM_CH-1:0] pend;
    @(posedge clk); #1;
    for (int i = 0; i < NUM_CH; i++) begin
      vals[i] = int'($urandom_range(0, 16383));
      value[14*i +: 14] = 14'(vals[i]);
    end
    pend = 4'b1010; req = pend;
    wait_ack(5, g, ok);
    for (int n = 0; n < 6; n++) begin
      exp = rr_pick(pend, m_last);
      checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL fair_ack%0d: got %b expected %b", n, ack, onehot(exp)); end
      ok = 1'b1; m_last = exp;
      @(posedge clk); #1;
      if (n == 5) begin req = '0; pend = '0; end
      else if (exp == 0) begin req[0] = 1'b0; pend[0] = 1'b0; end
      if (n == 1) begin req[0] = 1'b1; pend[0] = 1'b1; end
      at_cycle(g + 32); g += 32;
      m_bcd[exp] = to_bcd(clampv(vals[exp]));
      checks++; if (done !== onehot(exp) || bcd !== mvec()) begin errors++;
        $display("FAIL fair_done%0d: got done=%b bcd=%h expected %b %h", n, done, bcd, onehot(exp), mvec()); end
    end
  endtask

  task automatic test_timeout;
    int g, exp, v; bit ok, done_seen;
    stuck = 1'b1;
    @(posedge clk); #1;
    v = int'($urandom_range(0, 9999));
    value[14 +: 14] = 14'(v); req[1] = 1'b1;
    exp = rr_pick(4'b0010, m_last);
    wait_ack(10, g, ok);
    checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL tmo_ack: got %b expected %b", ack, onehot(exp)); end
    m_last = exp;
    @(posedge clk); #1 req[1] = 1'b0;
    done_seen = 1'b0;
    for (int t = g + 1; t <= g + 45; t++) begin
      at_cycle(t);
      if (done !== '0) done_seen = 1'b1;
      if (t == g + 41) begin
        checks++; if (err !== m_err) begin errors++; $display("FAIL tmo_err_early: got %b expected %b", err, m_err); end
      end
      if (t == g + 43) begin
        m_err = 1'b1;
        checks++; if (err !== m_err) begin errors++; $display("FAIL tmo_err: got %b expected %b", err, m_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_arb: got busy=%b expected 0", busy); end
      end
    end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL tmo_no_done: got done pulse=%b expected 0", done_seen); end
    checks++; if (bcd !== mvec()) begin errors++; $display("FAIL tmo_bcd_hold: got %h expected %h", bcd, mvec()); end
    stuck = 1'b0;
    @(posedge clk); #1;
    v = int'($urandom_range(0, 16383));
    value[14 +: 14] = 14'(v); req[1] = 1'b1;
    exp = rr_pick(4'b0010, m_last);
    wait_ack(10, g, ok);
    checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL tmo_retry_ack: got %b expected %b", ack, onehot(exp)); end
    m_last = exp;
    @(posedge clk); #1 req[1] = 1'b0;
    at_cycle(g + 32);
    m_bcd[1] = to_bcd(clampv(v));
    checks++; if (done !== onehot(1) || bcd !== mvec()) begin errors++;
      $display("FAIL tmo_retry_done: got done=%b bcd=%h expected %b %h", done, bcd, onehot(1), mvec()); end
    checks++; if (err !== m_err) begin errors++; $display("FAIL tmo_err_sticky: got %b expected %b", err, m_err); end
  endtask

  task automatic test_reset_mid;
    int g, exp; bit ok, done_seen;
    @(posedge clk); #1;
    value[0 +: 14] = 14'($urandom_range(0, 9999)); req[0] = 1'b1;
    exp = rr_pick(4'b0001, m_last);
    wait_ack(10, g, ok);
    checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL rmid_ack: got %b expected %b", ack, onehot(exp)); end
    @(posedge clk); #1 req[0] = 1'b0;
    at_cycle(g + 9);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
    checks++; if ({ack, done, busy, err, conv_start} !== '0 || bcd !== '0 || conv_in !== '0) begin errors++;
      $display("FAIL rmid_outputs: got ack=%b done=%b busy=%b err=%b start=%b bcd=%h conv_in=%0d expected all 0",
               ack, done, busy, err, conv_start, bcd, conv_in); end
    done_seen = 1'b0;
    for (int t = g + 12; t <= g + 40; t++) begin
      at_cycle(t);
      if (done !== '0) done_seen = 1'b1;
    end
    checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rmid_no_done: got done pulse=%b expected 0", done_seen); end
    @(posedge clk); #1;
    value[0 +: 14] = 14'd57; req[0] = 1'b1;
    exp = rr_pick(4'b0001, m_last);
    wait_ack(10, g, ok);
    checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL rmid_re_ack: got %b expected %b", ack, onehot(exp)); end
    m_last = exp;
    @(posedge clk); #1 req[0] = 1'b0;
    at_cycle(g + 32);
    m_bcd[0] = to_bcd(57);
    checks++; if (done !== onehot(0) || bcd !== mvec()) begin errors++;
      $display("FAIL rmid_re_done: got done=%b bcd=%h expected %b %h", done, bcd, onehot(0), mvec()); end
  endtask

  task automatic test_random;
    int g, exp; bit ok;
    int vals [NUM_CH];
    logic [NUM_CH-1:0] pend;
    for (int r = 0; r < 10; r++) begin
      @(posedge clk); #1;
      pend = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      for (int i = 0; i < NUM_CH; i++) begin
        vals[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
        value[14*i +: 14] = 14'(vals[i]);
      end
      req = pend;
      wait_ack(5, g, ok);
      while (pend != '0) begin
        exp = rr_pick(pend, m_last);
        checks++; if (!ok || ack !== onehot(exp)) begin errors++; $display("FAIL rand_ack r%0d: got %b expected %b", r, ack, onehot(exp)); end
        ok = 1'b1; m_last = exp; pend[exp] = 1'b0;
        @(posedge clk); #1 req[exp] = 1'b0;
        at_cycle(g + 32); g += 32;
        m_bcd[exp] = to_bcd(clampv(vals[exp]));
        checks++; if (done !== onehot(exp) || bcd !== mvec()) begin errors++;
          $display("FAIL rand_done r%0d: got done=%b bcd=%h expected %b %h", r, done, bcd, onehot(exp), mvec()); end
      end
    end
    checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err: got %b expected %b", err, m_err); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_clamp();
    test_all_four();
    test_fairness();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
